regfile_port_ctrl: RTL and testbench
====================================

Name: regfile_port_ctrl

Overview:
- Controller in front of the 64-bit, 32-entry integer register file.
- Arbitrates its single write port among NUM_REQ writeback sources (ALU, load, CSR) with round-robin valid/ready handshakes.
- Keeps a per-register pending-write scoreboard for issue hazard checks.
- Sequences the register-file dump so that it happens only after in-flight writes drain.

Parameters:
- DATA_WIDTH, 64, register data width.
- REGISTER_AMOUNT_LOG, 5, register index width (2**5 = 32 registers).
- NUM_REQ, 3, number of writeback requesters (2..8).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- wb_valid  in  NUM_REQ  per-requester writeback valid.
- wb_rd  in  NUM_REQ*REGISTER_AMOUNT_LOG  destination index; requester i uses slice [i*RAL +: RAL].
- wb_data  in  NUM_REQ*DATA_WIDTH  writeback data; requester i uses slice [i*DW +: DW].
- wb_ready  out  NUM_REQ  one-hot grant; a transfer occurs when wb_valid[i] and wb_ready[i] are both high.
- issue_valid  in  1  decode wants to allocate destination issue_rd.
- issue_rd  in  REGISTER_AMOUNT_LOG  destination being allocated.
- issue_stall  out  1  allocation refused this cycle.
- rs1, rs2  in  REGISTER_AMOUNT_LOG each  source indices to check.
- rs1_busy, rs2_busy  out  1 each  source has a pending write.
- dump_req  in  1  level request for a register dump.
- dump_ack  out  1  one-cycle pulse when the dump is complete.
- write_reg  out  REGISTER_AMOUNT_LOG  to register file.
- write_data  out  DATA_WIDTH  to register file.
- dump  out  1  to register file.

Behaviour:
- Reset (synchronous, active-high), all sampled at the reset edge:
  - busy[31:0] = 0, rr_ptr = 0, state = IDLE, wr_pend = 0.
  - write_reg = 0, write_data = 0, dump = 0, dump_ack = 0.
  - A reset mid-drain or mid-dump aborts: no dump and no dump_ack are produced.
- Idle write port: write_reg = 0 and write_data = 0. The register file forces x0 to zero on such a write, so this is harmless.
- Arbitration (state IDLE only):
  - Grant the first asserted wb_valid searching from rr_ptr upward, modulo NUM_REQ.
  - wb_ready is combinational from wb_valid, rr_ptr and state. At most one bit is high; none is high if no wb_valid is high.
  - On a transfer from requester g, rr_ptr <= (g+1) mod NUM_REQ. With no transfer, rr_ptr holds.
  - A requester must hold valid, rd and data stable until its transfer.
- Write pipeline, 1-cycle latency:
  - On a transfer at edge N: write_reg/write_data are registered with the granted rd/data, and wr_pend <= 1. The register file captures the write at edge N+1.
  - With no transfer: write_reg/write_data return to 0 and wr_pend <= 0.
- Scoreboard:
  - busy[0] is hardwired to 0.
  - issue_stall = issue_valid && (busy[issue_rd] || state != IDLE).
  - When issue_valid is high and issue_stall is low, busy[issue_rd] <= 1 (ignored when issue_rd = 0).
  - The registered write stage (wr_pend = 1, write_reg = r != 0) clears busy[r] at the edge where the register file captures the write.
  - If a set and a clear target the same index at the same edge, the set wins.
  - A writeback to a non-busy register is legal and leaves the scoreboard unchanged. A writeback to rd = 0 is accepted and affects nothing.
  - rs1_busy = busy[rs1] and rs2_busy = busy[rs2], combinational from current state. There is no bypass.
- Dump FSM, states IDLE, DRAIN, DUMP, DONE:
  - IDLE: when dump_req is high, go to DRAIN. Arbitration stops at the same cycle the DRAIN state is entered.
  - DRAIN: wb_ready = 0. When wr_pend == 0, go to DUMP.
  - DUMP: dump = 1 for exactly one cycle with write_reg = 0; go to DONE.
  - DONE: dump_ack = 1 for one cycle; go to IDLE.
  - The requester drops dump_req on seeing dump_ack. If dump_req is still high in IDLE, a new dump starts.
  - The scoreboard retains its state across a dump.

Test Plan:
- Reset, then wb_valid = 3'b111, all held: grants go 0,1,2,0,…. write_reg follows the respective rd exactly one cycle after each handshake. Exactly one wb_ready is high per cycle.
- Issue rd = 5 (accepted), then issue rd = 5 again: the second is stalled and rs1 = 5 reads rs1_busy = 1. Requester 1 writes rd 5 = 0xDEAD at edge N: busy[5] clears at edge N+1, rs1_busy = 0 the cycle after, and the register file holds 0xDEAD.
- Issue rd = 0 and writeback rd = 0 with data 0x1234: issue_stall = 0, busy stays all-zero, write_reg = 0.
- Hold a transfer pending, then raise dump_req: the in-flight write lands, wb_ready stays 0 during DRAIN, dump is high for exactly 1 cycle, then dump_ack pulses and arbitration resumes.
- Assert reset the cycle dump = 1 is expected (in DRAIN): no dump and no dump_ack follow. All outputs are 0 and busy is cleared the following cycle.
- Simultaneous issue of rd = 7 (not busy) and write-stage clear of rd = 7: busy[7] = 1 afterwards.

Source files
------------

// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: single write port of the 32-entry integer register file shared by
//   NUM_REQ writeback sources, plus pending-write scoreboard and dump sequencer.
// Latency: a granted writeback appears on write_reg/write_data one cycle after the handshake.
// Backpressure: wb_ready is a one-hot round-robin grant, forced low outside IDLE (dump drain).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   wb_valid/rd/data      per-requester writeback request; wb_ready one-hot grant
//   issue_valid/issue_rd  destination allocation; issue_stall refuses it
//   rs1/rs2 -> *_busy     source hazard lookup (no bypass)
//   dump_req/dump_ack     level request / completion pulse for a register dump
//   write_reg/write_data/dump  register file write port and dump strobe
module regfile_port_ctrl #(
  parameter int DATA_WIDTH          = 64,
  parameter int REGISTER_AMOUNT_LOG = 5,
  parameter int NUM_REQ             = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQ-1:0]                     wb_valid,
  input  logic [NUM_REQ*REGISTER_AMOUNT_LOG-1:0] wb_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]          wb_data,
  output logic [NUM_REQ-1:0]                     wb_ready,
  input  logic                                   issue_valid,
  input  logic [REGISTER_AMOUNT_LOG-1:0]         issue_rd,
  output logic                                   issue_stall,
  input  logic [REGISTER_AMOUNT_LOG-1:0]         rs1,
  input  logic [REGISTER_AMOUNT_LOG-1:0]         rs2,
  output logic                                   rs1_busy,
  output logic                                   rs2_busy,
  input  logic                                   dump_req,
  output logic                                   dump_ack,
  output logic [REGISTER_AMOUNT_LOG-1:0]         write_reg,
  output logic [DATA_WIDTH-1:0]                  write_data,
  output logic                                   dump
);

  localparam int NREG  = 1 << REGISTER_AMOUNT_LOG;
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, DRAIN, DUMP, DONE} state_t;

  state_t                         state_q;
  logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [NREG-1:0]                busy_q, busy_d;
  logic                           wr_pend_q;
  logic [REGISTER_AMOUNT_LOG-1:0] write_reg_q;
  logic [DATA_WIDTH-1:0]          write_data_q;
  logic                           dump_q;
  logic                           dump_ack_q;

  // Per-requester views of the flattened request buses.
  logic [REGISTER_AMOUNT_LOG-1:0] req_rd   [NUM_REQ];
  logic [DATA_WIDTH-1:0]          req_data [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_rd[i]   = wb_rd[i*REGISTER_AMOUNT_LOG +: REGISTER_AMOUNT_LOG];
    assign req_data[i] = wb_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin arbiter: scan from rr_ptr upward with wrap, take the first valid.
  logic [NUM_REQ-1:0]             grant;
  logic                           xfer;
  logic [REGISTER_AMOUNT_LOG-1:0] grant_rd;
  logic [DATA_WIDTH-1:0]          grant_data;
  logic [PTR_W-1:0]               cand;
  int                             cand_i;

  always_comb begin
    grant      = '0;
    xfer       = 1'b0;
    grant_rd   = '0;
    grant_data = '0;
    rr_ptr_d   = rr_ptr_q;
    cand       = '0;
    cand_i     = 0;
    if (state_q == IDLE) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        // rr_ptr_q < NUM_REQ, so one subtraction is enough to wrap.
        cand_i = int'(rr_ptr_q) + k;
        if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
        cand = cand_i[PTR_W-1:0];
        if (!xfer && wb_valid[cand]) begin
          xfer        = 1'b1;
          grant[cand] = 1'b1;
          grant_rd    = req_rd[cand];
          grant_data  = req_data[cand];
          rr_ptr_d    = (cand_i + 1 >= NUM_REQ) ? '0 : PTR_W'(cand_i + 1);
        end
      end
    end
  end

  assign wb_ready = grant;

  // Scoreboard: stall also covers the whole dump sequence so nothing new is allocated.
  assign issue_stall = issue_valid && (busy_q[issue_rd] || state_q != IDLE);
  assign rs1_busy    = busy_q[rs1];
  assign rs2_busy    = busy_q[rs2];

  always_comb begin
    busy_d = busy_q;
    // The write stage retires at the edge the register file captures it.
    if (wr_pend_q && write_reg_q != '0) busy_d[write_reg_q] = 1'b0;
    // Applied after the clear so a same-index allocation wins.
    if (issue_valid && !issue_stall) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      busy_q       <= '0;
      wr_pend_q    <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      dump_q       <= 1'b0;
      dump_ack_q   <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      busy_q       <= busy_d;
      wr_pend_q    <= xfer;
      // An idle write port presents x0/0, which the register file discards.
      write_reg_q  <= xfer ? grant_rd : '0;
      write_data_q <= xfer ? grant_data : '0;
      dump_q       <= 1'b0;
      dump_ack_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dump_req) state_q <= DRAIN;
        end
        DRAIN: begin
          // Leave only once the last granted write has been presented.
          if (!wr_pend_q) begin
            state_q <= DUMP;
            dump_q  <= 1'b1;
          end
        end
        DUMP: begin
          state_q    <= DONE;
          dump_ack_q <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign dump       = dump_q;
  assign dump_ack   = dump_ack_q;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// tb_regfile_port_ctrl: directed scenarios plus randomized traffic for regfile_port_ctrl,
// each checked against a cycle-level behavioural model of the controller and a model
// of the register file contents.
module tb_regfile_port_ctrl;

  localparam int DW  = 64;
  localparam int RAL = 5;
  localparam int N   = 3;
  localparam int OW  = N + 5 + RAL + DW;

  localparam int PH_IDLE  = 0;
  localparam int PH_DRAIN = 1;
  localparam int PH_DUMP  = 2;
  localparam int PH_DONE  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      wb_valid;
  logic [N*RAL-1:0]  wb_rd;
  logic [N*DW-1:0]   wb_data;
  logic [N-1:0]      wb_ready;
  logic              issue_valid;
  logic [RAL-1:0]    issue_rd;
  logic              issue_stall;
  logic [RAL-1:0]    rs1, rs2;
  logic              rs1_busy, rs2_busy;
  logic              dump_req;
  logic              dump_ack;
  logic [RAL-1:0]    write_reg;
  logic [DW-1:0]     write_data;
  logic              dump;

  logic [OW-1:0]     obs_v;

  int n_vec = 0;
  int n_err = 0;

  // Register file emulation fed by the DUT's write port.
  logic [DW-1:0] tb_rf [32] = '{default: '0};

  // Reference model state.
  bit [31:0]   m_busy;
  int          m_rr;
  int          m_phase;
  bit          m_pend;
  bit [RAL-1:0] m_prd;
  bit [DW-1:0] m_pdata;
  bit [DW-1:0] m_regs [32];

  always #5 clk = ~clk;

  regfile_port_ctrl #(
    .DATA_WIDTH(DW),
    .REGISTER_AMOUNT_LOG(RAL),
    .NUM_REQ(N)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wb_valid(wb_valid),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .wb_ready(wb_ready),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .issue_stall(issue_stall),
    .rs1(rs1),
    .rs2(rs2),
    .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy),
    .dump_req(dump_req),
    .dump_ack(dump_ack),
    .write_reg(write_reg),
    .write_data(write_data),
    .dump(dump)
  );

  assign obs_v = {wb_ready, issue_stall, rs1_busy, rs2_busy, dump, dump_ack, write_reg, write_data};

  always @(posedge clk) begin
    if (write_reg != '0) tb_rf[write_reg] <= write_data;
  end

  // Requester that the model grants this cycle, or -1.
  function automatic int m_grant();
    if (m_phase != PH_IDLE) return -1;
    for (int k = 0; k < N; k++) begin
      if (wb_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [OW-1:0] m_expect();
    int           g;
    logic [N-1:0] rdy;
    logic         stall;
    g   = m_grant();
    rdy = '0;
    if (g >= 0) rdy[g] = 1'b1;
    stall = issue_valid && (m_busy[issue_rd] || m_phase != PH_IDLE);
    return {rdy, stall, m_busy[rs1], m_busy[rs2], m_phase == PH_DUMP, m_phase == PH_DONE,
            m_pend ? m_prd : 5'd0, m_pend ? m_pdata : 64'd0};
  endfunction

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    int g;
    bit acc;
    g   = m_grant();
    acc = issue_valid && !(m_busy[issue_rd] || m_phase != PH_IDLE);
    if (m_pend && m_prd != 0) m_regs[m_prd] = m_pdata;
    if (reset) begin
      m_busy = '0; m_rr = 0; m_phase = PH_IDLE; m_pend = 0; m_prd = '0; m_pdata = '0;
      return;
    end
    if (m_pend && m_prd != 0) m_busy[m_prd] = 1'b0;
    if (acc && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    case (m_phase)
      PH_IDLE:  if (dump_req) m_phase = PH_DRAIN;
      PH_DRAIN: if (!m_pend) m_phase = PH_DUMP;
      PH_DUMP:  m_phase = PH_DONE;
      default:  m_phase = PH_IDLE;
    endcase
    if (g >= 0) begin
      m_pend  = 1'b1;
      m_prd   = wb_rd[g*RAL +: RAL];
      m_pdata = wb_data[g*DW +: DW];
      m_rr    = (g + 1) % N;
    end else begin
      m_pend = 1'b0; m_prd = '0; m_pdata = '0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = '0; issue_valid = 1'b0; dump_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wb_valid = '0; wb_rd = '0; wb_data = '0; issue_valid = 1'b0;
    issue_rd = '0; rs1 = '0; rs2 = '0; dump_req = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy = '0; m_rr = 0; m_phase = PH_IDLE; m_pend = 0; m_prd = '0; m_pdata = '0;
    tick(); tick();
    reset = 1'b0; #1;
    n_vec++;
    if (obs_v !== '0) begin
      n_err++; $display("FAIL reset_outputs got=%h want=0", obs_v);
    end
    n_vec++;
    if (obs_v !== m_expect()) begin
      n_err++; $display("FAIL reset_model got=%h want=%h", obs_v, m_expect());
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0]   exp_g;
    logic [RAL-1:0] prev_rd;
    prev_rd = '0;
    wb_valid = '1;
    for (int i = 0; i < N; i++) begin
      wb_rd[i*RAL +: RAL] = RAL'(i + 1);
      wb_data[i*DW +: DW] = 64'hA0 + 64'(i);
    end
    #1;
    for (int c = 0; c < 9; c++) begin
      exp_g = N'(1) << (c % 3);
      n_vec++;
      if (wb_ready !== exp_g) begin
        n_err++; $display("FAIL rr_grant cyc=%0d got=%b want=%b", c, wb_ready, exp_g);
      end
      n_vec++;
      if (obs_v !== m_expect()) begin
        n_err++; $display("FAIL rr_model cyc=%0d got=%h want=%h", c, obs_v, m_expect());
      end
      if (c > 0) begin
        n_vec++;
        if (write_reg !== prev_rd) begin
          n_err++; $display("FAIL rr_write_reg cyc=%0d got=%0d want=%0d", c, write_reg, prev_rd);
        end
      end
      prev_rd = RAL'((c % 3) + 1);
      tick(); #1;
    end
    idle_inputs(); tick();
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_rd = 5'd5; rs1 = 5'd5; rs2 = 5'd0; #1;
    n_vec++;
    if ({issue_stall, rs1_busy} !== 2'b00) begin
      n_err++; $display("FAIL sb_first_issue got stall/busy=%b want=00", {issue_stall, rs1_busy});
    end
    tick();
    wb_valid = 3'b010; wb_rd[RAL +: RAL] = 5'd5; wb_data[DW +: DW] = 64'hDEAD; #1;
    n_vec++;
    if ({issue_stall, rs1_busy, wb_ready} !== 5'b11010) begin
      n_err++; $display("FAIL sb_second_issue got=%b want=11010", {issue_stall, rs1_busy, wb_ready});
    end
    n_vec++;
    if (obs_v !== m_expect()) begin
      n_err++; $display("FAIL sb_model_b got=%h want=%h", obs_v, m_expect());
    end
    tick();
    issue_valid = 1'b0; wb_valid = '0; #1;
    n_vec++;
    if ({write_reg, write_data, rs1_busy} !== {5'd5, 64'hDEAD, 1'b1}) begin
      n_err++; $display("FAIL sb_write_stage got reg=%0d data=%h busy=%b want 5/dead/1",
                        write_reg, write_data, rs1_busy);
    end
    tick(); #1;
    n_vec++;
    if (rs1_busy !== 1'b0) begin
      n_err++; $display("FAIL sb_cleared got=%b want=0", rs1_busy);
    end
    n_vec++;
    if (tb_rf[5] !== 64'hDEAD) begin
      n_err++; $display("FAIL sb_regfile got=%h want=dead", tb_rf[5]);
    end
    n_vec++;
    if (obs_v !== m_expect()) begin
      n_err++; $display("FAIL sb_model_d got=%h want=%h", obs_v, m_expect());
    end
  endtask

  task automatic test_x0();
    logic [31:0] seen;
    issue_valid = 1'b1; issue_rd = 5'd0;
    wb_valid = 3'b001; wb_rd[0 +: RAL] = 5'd0; wb_data[0 +: DW] = 64'h1234; #1;
    n_vec++;
    if ({issue_stall, wb_ready} !== 4'b0001) begin
      n_err++; $display("FAIL x0_issue got=%b want=0001", {issue_stall, wb_ready});
    end
    tick();
    issue_valid = 1'b0; wb_valid = '0; #1;
    n_vec++;
    if (write_reg !== 5'd0) begin
      n_err++; $display("FAIL x0_write_reg got=%0d want=0", write_reg);
    end
    n_vec++;
    if (obs_v !== m_expect()) begin
      n_err++; $display("FAIL x0_model got=%h want=%h", obs_v, m_expect());
    end
    tick();
    seen = '0;
    for (int i = 0; i < 32; i++) begin
      rs1 = RAL'(i); rs2 = RAL'(31 - i); #1;
      seen[i] = rs1_busy | rs2_busy;
    end
    n_vec++;
    if (seen !== 32'd0) begin
      n_err++; $display("FAIL x0_busy_scan got=%h want=0", seen);
    end
    rs1 = '0; rs2 = '0;
  endtask

  task automatic test_dump();
    bit seen_ack, leak;
    int dump_cnt;
    seen_ack = 0; leak = 0; dump_cnt = 0;
    wb_valid = 3'b100; wb_rd[2*RAL +: RAL] = 5'd9; wb_data[2*DW +: DW] = 64'hC0FFEE;
    dump_req = 1'b1; #1;
    n_vec++;
    if (wb_ready !== 3'b100) begin
      n_err++; $display("FAIL dump_pre_grant got=%b want=100", wb_ready);
    end
    tick();
    wb_valid = 3'b001; wb_rd[0 +: RAL] = 5'd10; wb_data[0 +: DW] = 64'hBEEF; #1;
    for (int c = 0; c < 10 && !seen_ack; c++) begin
      n_vec++;
      if (obs_v !== m_expect()) begin
        n_err++; $display("FAIL dump_model cyc=%0d got=%h want=%h", c, obs_v, m_expect());
      end
      if (c == 0) begin
        n_vec++;
        if (write_reg !== 5'd9) begin
          n_err++; $display("FAIL dump_inflight got=%0d want=9", write_reg);
        end
      end
      if (dump) dump_cnt++;
      if (wb_ready != '0) leak = 1;
      if (dump_ack) begin seen_ack = 1; dump_req = 1'b0; end
      tick(); #1;
    end
    n_vec++;
    if ({seen_ack, leak} !== 2'b10) begin
      n_err++; $display("FAIL dump_ack_ready got ack/leak=%b want=10", {seen_ack, leak});
    end
    n_vec++;
    if (dump_cnt !== 1) begin
      n_err++; $display("FAIL dump_width got=%0d want=1", dump_cnt);
    end
    n_vec++;
    if (tb_rf[9] !== 64'hC0FFEE) begin
      n_err++; $display("FAIL dump_drained_write got=%h want=c0ffee", tb_rf[9]);
    end
    n_vec++;
    if (wb_ready !== 3'b001) begin
      n_err++; $display("FAIL dump_resume got=%b want=001", wb_ready);
    end
    tick();
    idle_inputs(); tick();
  endtask

  task automatic test_reset_in_dump();
    bit stray;
    stray = 0;
    issue_valid = 1'b1; issue_rd = 5'd3; rs1 = 5'd3; dump_req = 1'b1; #1;
    n_vec++;
    if (issue_stall !== 1'b0) begin
      n_err++; $display("FAIL rst_dump_issue got=%b want=0", issue_stall);
    end
    tick();
    issue_valid = 1'b0; reset = 1'b1; #1;
    n_vec++;
    if ({dump, rs1_busy} !== 2'b01) begin
      n_err++; $display("FAIL rst_dump_drain got dump/busy=%b want=01", {dump, rs1_busy});
    end
    tick();
    reset = 1'b0; dump_req = 1'b0; #1;
    n_vec++;
    if (obs_v !== '0) begin
      n_err++; $display("FAIL rst_dump_outputs got=%h want=0", obs_v);
    end
    for (int c = 0; c < 4; c++) begin
      tick(); #1;
      if (dump || dump_ack) stray = 1;
    end
    n_vec++;
    if (stray !== 1'b0) begin
      n_err++; $display("FAIL rst_dump_aborted got=%b want=0", stray);
    end
  endtask

  task automatic test_collision();
    wb_valid = 3'b001; wb_rd[0 +: RAL] = 5'd7; wb_data[0 +: DW] = 64'h77; #1;
    n_vec++;
    if (wb_ready !== 3'b001) begin
      n_err++; $display("FAIL coll_grant got=%b want=001", wb_ready);
    end
    tick();
    wb_valid = '0; issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7; #1;
    n_vec++;
    if ({write_reg, issue_stall, rs1_busy} !== {5'd7, 2'b00}) begin
      n_err++; $display("FAIL coll_setup got reg=%0d stall=%b busy=%b want 7/0/0",
                        write_reg, issue_stall, rs1_busy);
    end
    tick();
    issue_valid = 1'b0; #1;
    n_vec++;
    if (rs1_busy !== 1'b1) begin
      n_err++; $display("FAIL coll_set_wins got=%b want=1", rs1_busy);
    end
    n_vec++;
    if (obs_v !== m_expect()) begin
      n_err++; $display("FAIL coll_model got=%h want=%h", obs_v, m_expect());
    end
  endtask

  task automatic test_random();
    logic [N-1:0] xfer_mask;
    int rf_bad;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!wb_valid[i] && $urandom_range(0, 1) == 1) begin
          wb_valid[i] = 1'b1;
          wb_rd[i*RAL +: RAL] = RAL'($urandom_range(0, 31));
          wb_data[i*DW +: DW] = {$urandom, $urandom};
        end
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd = RAL'($urandom_range(0, 31));
      rs1 = RAL'($urandom_range(0, 31));
      rs2 = RAL'($urandom_range(0, 31));
      if (!dump_req && $urandom_range(0, 49) == 0) dump_req = 1'b1;
      #1;
      n_vec++;
      if (obs_v !== m_expect()) begin
        n_err++; $display("FAIL rand_model cyc=%0d got=%h want=%h", c, obs_v, m_expect());
      end
      if (dump_ack) dump_req = 1'b0;
      xfer_mask = wb_valid & wb_ready;
      tick();
      wb_valid = wb_valid & ~xfer_mask;
    end
    idle_inputs(); tick(); tick();
    rf_bad = 0;
    for (int i = 0; i < 32; i++) if (tb_rf[i] !== m_regs[i]) rf_bad++;
    n_vec++;
    if (rf_bad != 0) begin
      n_err++; $display("FAIL rand_regfile got=%0d differing registers want=0", rf_bad);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_scoreboard();
    test_x0();
    test_dump();
    test_reset_in_dump();
    test_collision();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
